// File: rtl/alu_2bit_exerciser_pkg.sv
// Shared constants, FSM encoding and the Hack ALU control-bit table
// for the 2-bit ALU exerciser.
package alu_2bit_exerciser_pkg;

  localparam int unsigned NUM_FUNCS   = 18;
  localparam int unsigned NUM_VECTORS = 288;

  localparam logic [8:0] NO_FAIL  = 9'h1FF;
  localparam logic [8:0] LAST_VEC = 9'(NUM_VECTORS - 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DRIVE  = 3'd1,
    ST_SETTLE = 3'd2,
    ST_CHECK  = 3'd3,
    ST_DONE   = 3'd4
  } state_e;

  // Bit order, MSB first: zx nx zy ny f no
  typedef logic [5:0] ctrl_t;

  localparam ctrl_t CTRL_TABLE [0:NUM_FUNCS-1] = '{
    6'b101010,  // 0
    6'b111111,  // 1
    6'b111010,  // -1
    6'b001100,  // x
    6'b110000,  // y
    6'b001101,  // !x
    6'b110001,  // !y
    6'b001111,  // -x
    6'b110011,  // -y
    6'b011111,  // x+1
    6'b110111,  // y+1
    6'b001110,  // x-1
    6'b110010,  // y-1
    6'b000010,  // x+y
    6'b010011,  // x-y
    6'b000111,  // y-x
    6'b000000,  // x&y
    6'b010101   // x|y
  };

  function automatic ctrl_t func_ctrl(input logic [4:0] func);
    ctrl_t c;
    if (func < 5'(NUM_FUNCS)) begin
      c = CTRL_TABLE[func];
    end else begin
      c = 6'b000000;
    end
    return c;
  endfunction

endpackage

// File: rtl/alu_2bit_exerciser_if.sv
// Operand/control/result bundle between the exerciser (master) and the
// ALU under test (slave).
interface alu_2bit_exerciser_if #(
  parameter int WIDTH = 2
);
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic             zx;
  logic             nx;
  logic             zy;
  logic             ny;
  logic             f;
  logic             no;
  logic [WIDTH-1:0] alu_out;
  logic             alu_zr;
  logic             alu_ng;

  modport master (
    output x, y, zx, nx, zy, ny, f, no,
    input  alu_out, alu_zr, alu_ng
  );

  modport slave (
    input  x, y, zx, nx, zy, ny, f, no,
    output alu_out, alu_zr, alu_ng
  );
endinterface

// File: rtl/alu_2bit_exerciser_golden.sv
// Arithmetic reference for the 18 Hack ALU functions on 2-bit operands;
// deliberately independent of the control-bit encoding.
module alu_2bit_golden
  import alu_2bit_exerciser_pkg::*;
(
  input  logic [4:0] func_i,
  input  logic [1:0] x_i,
  input  logic [1:0] y_i,
  output logic [1:0] exp_out_o,
  output logic       exp_zr_o,
  output logic       exp_ng_o
);

  logic [1:0] res_s;

  // Result of the selected function, modulo 4
  always_comb begin
    res_s = 2'd0;
    case (func_i)
      5'd0:    res_s = 2'd0;
      5'd1:    res_s = 2'd1;
      5'd2:    res_s = 2'd3;
      5'd3:    res_s = x_i;
      5'd4:    res_s = y_i;
      5'd5:    res_s = ~x_i;
      5'd6:    res_s = ~y_i;
      5'd7:    res_s = 2'd0 - x_i;
      5'd8:    res_s = 2'd0 - y_i;
      5'd9:    res_s = x_i + 2'd1;
      5'd10:   res_s = y_i + 2'd1;
      5'd11:   res_s = x_i - 2'd1;
      5'd12:   res_s = y_i - 2'd1;
      5'd13:   res_s = x_i + y_i;
      5'd14:   res_s = x_i - y_i;
      5'd15:   res_s = y_i - x_i;
      5'd16:   res_s = x_i & y_i;
      5'd17:   res_s = x_i | y_i;
      default: res_s = 2'd0;
    endcase
  end

  assign exp_out_o = res_s;
  assign exp_zr_o  = (res_s == 2'd0);
  assign exp_ng_o  = res_s[1];

endmodule

// File: rtl/alu_2bit_exerciser.sv
// Sequencer that walks all 288 (function, x, y) vectors through the ALU
// under test and accumulates pass/fail, error count and first failing index.
module alu_2bit_exerciser
  import alu_2bit_exerciser_pkg::*;
#(
  parameter int WIDTH         = 2,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  alu_2bit_exerciser_if.master alu,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [8:0]           err_count,
  output logic [8:0]           first_fail
);

  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES);

  state_e           state_q;
  logic [8:0]       vec_q;
  logic [3:0]       settle_q;
  logic [8:0]       err_q;
  logic [8:0]       err_d;
  logic [8:0]       first_q;
  logic [WIDTH-1:0] x_q;
  logic [WIDTH-1:0] y_q;
  ctrl_t            ctrl_q;
  logic             busy_q;
  logic             done_q;
  logic             pass_q;

  logic [1:0]       exp_out_s;
  logic             exp_zr_s;
  logic             exp_ng_s;
  logic             mismatch_s;

  // The index layout {func, x, y} is exactly func*16 + x*4 + y.
  alu_2bit_golden u_golden (
    .func_i    (vec_q[8:4]),
    .x_i       (vec_q[3:2]),
    .y_i       (vec_q[1:0]),
    .exp_out_o (exp_out_s),
    .exp_zr_o  (exp_zr_s),
    .exp_ng_o  (exp_ng_s)
  );

  // Compare the ALU response with the reference and form the next error count
  always_comb begin
    mismatch_s = (alu.alu_out != exp_out_s) ||
                 (alu.alu_zr  != exp_zr_s)  ||
                 (alu.alu_ng  != exp_ng_s);
    if (mismatch_s) begin
      err_d = err_q + 9'd1;
    end else begin
      err_d = err_q;
    end
  end

  // Run sequencer with registered drive and status outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      vec_q    <= 9'd0;
      settle_q <= 4'd0;
      err_q    <= 9'd0;
      first_q  <= NO_FAIL;
      x_q      <= '0;
      y_q      <= '0;
      ctrl_q   <= 6'b000000;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            err_q   <= 9'd0;
            first_q <= NO_FAIL;
            vec_q   <= 9'd0;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            state_q <= ST_DRIVE;
          end
        end
        ST_DRIVE: begin
          x_q      <= vec_q[3:2];
          y_q      <= vec_q[1:0];
          ctrl_q   <= func_ctrl(vec_q[8:4]);
          settle_q <= SETTLE_LOAD;
          state_q  <= ST_SETTLE;
        end
        ST_SETTLE: begin
          if (settle_q <= 4'd1) begin
            state_q <= ST_CHECK;
          end else begin
            settle_q <= settle_q - 4'd1;
          end
        end
        ST_CHECK: begin
          err_q <= err_d;
          // err_q still zero means no earlier vector has failed
          if (mismatch_s && (err_q == 9'd0)) begin
            first_q <= vec_q;
          end
          if (vec_q == LAST_VEC) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            pass_q  <= (err_d == 9'd0);
            state_q <= ST_DONE;
          end else begin
            vec_q   <= vec_q + 9'd1;
            state_q <= ST_DRIVE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign alu.x  = x_q;
  assign alu.y  = y_q;
  assign alu.zx = ctrl_q[5];
  assign alu.nx = ctrl_q[4];
  assign alu.zy = ctrl_q[3];
  assign alu.ny = ctrl_q[2];
  assign alu.f  = ctrl_q[1];
  assign alu.no = ctrl_q[0];

  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign err_count  = err_q;
  assign first_fail = first_q;

endmodule

// File: tb/tb_alu_2bit_exerciser.sv
// Bench: a control-bit Hack ALU with injectable flag faults is attached to
// two exercisers (default settle and SETTLE_CYCLES=3).
module tb_alu_2bit_exerciser;
  import alu_2bit_exerciser_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset = 1'b0;
  logic start0 = 1'b0;
  logic start3 = 1'b0;
  int   fault_mode = 0;

  int checks = 0;
  int errors = 0;

  alu_2bit_exerciser_if #(.WIDTH(2)) if0 ();
  alu_2bit_exerciser_if #(.WIDTH(2)) if3 ();

  logic       busy0, done0, pass0, busy3, done3, pass3;
  logic [8:0] err0, first0, err3, first3;

  alu_2bit_exerciser #(.WIDTH(2), .SETTLE_CYCLES(1)) u_dut0 (
    .clk(clk), .reset(reset), .start(start0), .alu(if0),
    .busy(busy0), .done(done0), .pass(pass0),
    .err_count(err0), .first_fail(first0)
  );

  alu_2bit_exerciser #(.WIDTH(2), .SETTLE_CYCLES(3)) u_dut3 (
    .clk(clk), .reset(reset), .start(start3), .alu(if3),
    .busy(busy3), .done(done3), .pass(pass3),
    .err_count(err3), .first_fail(first3)
  );

  // Reference Hack ALU driven through the control bits; returns {out, zr, ng}
  function automatic logic [3:0] hack_alu(input logic [5:0] c, input logic [1:0] a, input logic [1:0] b);
    logic [1:0] xa, yb, o;
    xa = c[5] ? 2'b00 : a;
    if (c[4]) xa = ~xa;
    yb = c[3] ? 2'b00 : b;
    if (c[2]) yb = ~yb;
    o = c[1] ? (xa + yb) : (xa & yb);
    if (c[0]) o = ~o;
    return {o, (o == 2'b00), o[1]};
  endfunction

  logic [3:0] r0, r3;
  always_comb begin
    r0 = hack_alu({if0.zx, if0.nx, if0.zy, if0.ny, if0.f, if0.no}, if0.x, if0.y);
    if0.alu_out = r0[3:2];
    if0.alu_zr  = (fault_mode == 1) ? 1'b0 : r0[1];
    if0.alu_ng  = (fault_mode == 2) ? 1'b0 : r0[0];
    r3 = hack_alu({if3.zx, if3.nx, if3.zy, if3.ny, if3.f, if3.no}, if3.x, if3.y);
    if3.alu_out = r3[3:2];
    if3.alu_zr  = r3[1];
    if3.alu_ng  = r3[0];
  end

  // Drive-stability monitor on the SETTLE_CYCLES=3 instance
  logic [9:0] drv3;
  logic [9:0] prev3 = 10'd0;
  int         run3 = 0;
  int         changes3 = 0;
  int         bad3 = 0;
  logic       mon_en = 1'b0;
  assign drv3 = {if3.x, if3.y, if3.zx, if3.nx, if3.zy, if3.ny, if3.f, if3.no};
  always @(negedge clk) begin
    if (mon_en) begin
      if (drv3 != prev3) begin
        prev3    <= drv3;
        run3     <= 1;
        changes3 <= changes3 + 1;
        if (changes3 > 0 && run3 != 5) bad3 <= bad3 + 1;
      end else begin
        run3 <= run3 + 1;
      end
    end
  end

  // Standalone reference instance for hand-computed spot checks
  logic [4:0] g_func;
  logic [1:0] g_x, g_y, g_out;
  logic       g_zr, g_ng;
  alu_2bit_golden u_gold (
    .func_i(g_func), .x_i(g_x), .y_i(g_y),
    .exp_out_o(g_out), .exp_zr_o(g_zr), .exp_ng_o(g_ng)
  );

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  task automatic run0(input bit mid, output int cycles);
    @(negedge clk);
    start0 = 1'b1;
    @(posedge clk);
    #1;
    start0 = 1'b0;
    check("start_busy", busy0, 1);
    check("start_done_clr", done0, 0);
    cycles = 0;
    while (!done0 && cycles < 3000) begin
      @(posedge clk);
      #1;
      cycles++;
      start0 = mid && (cycles == 100);
    end
    start0 = 1'b0;
  endtask

  typedef struct {
    logic [4:0] func;
    logic [1:0] x, y, out;
    logic       zr, ng;
  } gold_vec_t;

  typedef struct {
    int mode;
    bit mid_pulse;
    bit exp_pass;
    int exp_err;
    int exp_first;
    int exp_cycles;
  } run_vec_t;

  gold_vec_t gv [8];
  run_vec_t  rv [5];

  initial begin
    int cyc;

    gv[0] = '{5'd13, 2'd3, 2'd2, 2'd1, 1'b0, 1'b0};
    gv[1] = '{5'd14, 2'd1, 2'd2, 2'd3, 1'b0, 1'b1};
    gv[2] = '{5'd7,  2'd1, 2'd0, 2'd3, 1'b0, 1'b1};
    gv[3] = '{5'd0,  2'd2, 2'd3, 2'd0, 1'b1, 1'b0};
    gv[4] = '{5'd17, 2'd1, 2'd2, 2'd3, 1'b0, 1'b1};
    gv[5] = '{5'd12, 2'd1, 2'd0, 2'd3, 1'b0, 1'b1};
    gv[6] = '{5'd5,  2'd1, 2'd3, 2'd2, 1'b0, 1'b1};
    gv[7] = '{5'd16, 2'd3, 2'd1, 2'd1, 1'b0, 1'b0};

    // mode: 0 correct ALU, 1 zr stuck at 0, 2 ng stuck at 0
    rv[0] = '{0, 1'b0, 1'b1, 0,   511, 864};
    rv[1] = '{1, 1'b0, 1'b0, 78,  0,   864};
    rv[2] = '{2, 1'b0, 1'b0, 136, 32,  864};
    rv[3] = '{0, 1'b1, 1'b1, 0,   511, 864};
    rv[4] = '{0, 1'b0, 1'b1, 0,   511, 864};

    #1 reset = 1'b1;
    #3;
    check("rst_busy", busy0, 0);
    check("rst_done", done0, 0);
    check("rst_pass", pass0, 0);
    check("rst_err", err0, 0);
    check("rst_first", first0, 511);
    check("rst_drive", {if0.x, if0.y, if0.zx, if0.nx, if0.zy, if0.ny, if0.f, if0.no}, 0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 8; i++) begin
      g_func = gv[i].func;
      g_x    = gv[i].x;
      g_y    = gv[i].y;
      #1;
      check($sformatf("gold%0d_out", i), g_out, gv[i].out);
      check($sformatf("gold%0d_zr", i), g_zr, gv[i].zr);
      check($sformatf("gold%0d_ng", i), g_ng, gv[i].ng);
    end

    // SETTLE_CYCLES=3: 5 cycles per vector, drive held stable across each
    @(negedge clk);
    mon_en = 1'b1;
    start3 = 1'b1;
    @(posedge clk);
    #1;
    start3 = 1'b0;
    cyc = 0;
    while (!done3 && cyc < 3000) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    mon_en = 1'b0;
    check("s3_cycles", cyc, 1440);
    check("s3_pass", pass3, 1);
    check("s3_err", err3, 0);
    check("s3_first", first3, 511);
    check("s3_changes", changes3, 288);
    check("s3_stable_bad", bad3, 0);

    for (int i = 0; i < 5; i++) begin
      fault_mode = rv[i].mode;
      run0(rv[i].mid_pulse, cyc);
      check($sformatf("run%0d_cycles", i), cyc, rv[i].exp_cycles);
      check($sformatf("run%0d_done", i), done0, 1);
      check($sformatf("run%0d_busy", i), busy0, 0);
      check($sformatf("run%0d_pass", i), pass0, rv[i].exp_pass);
      check($sformatf("run%0d_err", i), err0, rv[i].exp_err);
      check($sformatf("run%0d_first", i), first0, rv[i].exp_first);
      repeat (3) @(posedge clk);
      #1;
      check($sformatf("run%0d_done_hold", i), done0, 1);
    end

    // Abort a faulty run mid-way with an asynchronous reset
    fault_mode = 1;
    @(negedge clk);
    start0 = 1'b1;
    @(posedge clk);
    #1;
    start0 = 1'b0;
    repeat (399) @(posedge clk);
    #2;
    check("abort_pre_err_nonzero", (err0 != 9'd0), 1);
    reset = 1'b1;
    #1;
    check("abort_busy", busy0, 0);
    check("abort_done", done0, 0);
    check("abort_pass", pass0, 0);
    check("abort_err", err0, 0);
    check("abort_first", first0, 511);
    check("abort_drive", {if0.x, if0.y, if0.zx, if0.nx, if0.zy, if0.ny, if0.f, if0.no}, 0);
    @(negedge clk);
    reset = 1'b0;
    fault_mode = 0;
    run0(1'b0, cyc);
    check("post_abort_cycles", cyc, 864);
    check("post_abort_pass", pass0, 1);
    check("post_abort_err", err0, 0);
    check("post_abort_first", first0, 511);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
